// File: rtl/regbank_pkg.sv
// ---------------------------------------------------------------------------
// regbank_pkg
//
// Purpose:
//   Shared constants and types for the register-bank write arbiter.
//   - DATA_W / ADDR_W / NUM_REGS give the geometry of the 64x32 bank.
//   - state_t holds the arbiter FSM encoding (CLEAR sequence vs. normal RUN).
//   - RR_A / RR_B name the two requesters for round-robin priority tracking.
//
// Ports: none (package).
// ---------------------------------------------------------------------------
package regbank_pkg;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 6;
    localparam int NUM_REGS = 64;

    // CLEAR is the reset state, so it takes the all-zero encoding.
    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    // Requester identifiers, used as the value of the round-robin pointer.
    localparam logic RR_A = 1'b0;
    localparam logic RR_B = 1'b1;

endpackage : regbank_pkg

// File: rtl/rr_arbiter2.sv
// ---------------------------------------------------------------------------
// rr_arbiter2
//
// Purpose:
//   Purely combinational two-way round-robin arbiter.
//   A lone requester is always granted and leaves the priority pointer alone.
//   When both request, the side named by rr_pri wins and the pointer flips to
//   the other side so the loser wins the next contested cycle.
//   With enable low nothing is granted and the pointer is held.
//
// Ports:
//   enable       in  1  arbitration allowed this cycle
//   a_valid      in  1  requester A pending
//   b_valid      in  1  requester B pending
//   rr_pri       in  1  current priority holder (RR_A / RR_B)
//   grant_a      out 1  A wins this cycle
//   grant_b      out 1  B wins this cycle
//   rr_pri_next  out 1  priority pointer for the next cycle
// ---------------------------------------------------------------------------
module rr_arbiter2
    import regbank_pkg::*;
(
    input  logic enable,
    input  logic a_valid,
    input  logic b_valid,
    input  logic rr_pri,
    output logic grant_a,
    output logic grant_b,
    output logic rr_pri_next
);

    logic contested;

    always_comb begin
        grant_a     = 1'b0;
        grant_b     = 1'b0;
        rr_pri_next = rr_pri;
        contested   = a_valid && b_valid;

        if (enable) begin
            if (contested) begin
                // Grants are mutually exclusive because rr_pri selects one side.
                grant_a     = (rr_pri == RR_A);
                grant_b     = (rr_pri == RR_B);
                rr_pri_next = (rr_pri == RR_A) ? RR_B : RR_A;
            end else begin
                grant_a = a_valid;
                grant_b = b_valid;
            end
        end
    end

endmodule : rr_arbiter2

// File: rtl/regbank_write_arbiter.sv
// ---------------------------------------------------------------------------
// regbank_write_arbiter
//
// Purpose:
//   Owns the single write port of the register bank. Two writeback sources
//   (A = ALU, B = load/memory) compete for the port through valid/ready
//   handshakes with round-robin priority. After reset, or on a clear_req pulse,
//   the block walks every register and writes zero, one per cycle, during which
//   neither requester is accepted.
//
//   Handshake: a transfer happens in a cycle where valid && ready are both
//   high. ready is combinational and never depends on anything later than the
//   current cycle's valids; a requester holds valid/addr/data stable until it
//   sees the transfer. At most one of a_ready / b_ready is high in any cycle.
//
//   Timing: a transfer in cycle N is registered at the end of N, so
//   EscrReg/RegEscr/datain present it during N+1 and the bank captures it at
//   the end of N+1.
//
// Configuration:
//   REGBANK_ARB_R0_ZERO_EN - when defined, accepted writes to register 0 still
//   handshake but never raise EscrReg, keeping register 0 at zero. The clear
//   sequence still writes register 0.
//
// Ports:
//   clk        in  1       system clock, rising edge
//   reset      in  1       synchronous active-high reset
//   clear_req  in  1       one-cycle pulse, starts a bank clear (ignored in CLEAR)
//   a_valid    in  1       requester A write pending
//   a_addr     in  ADDR_W  requester A target register
//   a_data     in  DATA_W  requester A write data
//   a_ready    out 1       requester A accepted this cycle (with a_valid)
//   b_valid    in  1       requester B write pending
//   b_addr     in  ADDR_W  requester B target register
//   b_data     in  DATA_W  requester B write data
//   b_ready    out 1       requester B accepted this cycle (with b_valid)
//   busy       out 1       high while the clear sequence runs
//   RegEscr    out ADDR_W  bank write address (registered)
//   EscrReg    out 1       bank write enable (registered)
//   datain     out DATA_W  bank write data (registered)
// ---------------------------------------------------------------------------
module regbank_write_arbiter
    import regbank_pkg::*;
#(
    parameter int DATA_W   = regbank_pkg::DATA_W,
    parameter int ADDR_W   = regbank_pkg::ADDR_W,
    parameter int NUM_REGS = regbank_pkg::NUM_REGS
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear_req,
    input  logic              a_valid,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_data,
    output logic              a_ready,
    input  logic              b_valid,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_data,
    output logic              b_ready,
    output logic              busy,
    output logic [ADDR_W-1:0] RegEscr,
    output logic              EscrReg,
    output logic [DATA_W-1:0] datain
);

    // Counter value of the final clear write.
    localparam logic [ADDR_W-1:0] CLR_LAST = ADDR_W'(NUM_REGS - 1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   cnt_q,   cnt_d;
    logic                rr_q,    rr_d;
    logic                we_q,    we_d;
    logic [ADDR_W-1:0]   addr_q,  addr_d;
    logic [DATA_W-1:0]   data_q,  data_d;

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    logic arb_en;
    logic grant_a;
    logic grant_b;
    logic rr_next;
    logic a_wr_en;

    // clear_req beats any simultaneous valid, and a reset cycle accepts
    // nothing so pending requests are dropped rather than half-taken.
    assign arb_en = (state_q == ST_RUN) && !clear_req && !reset;

    rr_arbiter2 u_arb (
        .enable      (arb_en),
        .a_valid     (a_valid),
        .b_valid     (b_valid),
        .rr_pri      (rr_q),
        .grant_a     (grant_a),
        .grant_b     (grant_b),
        .rr_pri_next (rr_next)
    );

    assign a_ready = grant_a;
    assign b_ready = grant_b;
    assign busy    = (state_q == ST_CLEAR);

`ifdef REGBANK_ARB_R0_ZERO_EN
    // Register 0 is hard-wired to zero: A's write to it is acknowledged but
    // never reaches the bank.
    assign a_wr_en = (a_addr != '0);
`else
    assign a_wr_en = 1'b1;
`endif

    // B gets the same treatment as A when the zero-register option is on.
    logic b_wr_en;
`ifdef REGBANK_ARB_R0_ZERO_EN
    assign b_wr_en = (b_addr != '0);
`else
    assign b_wr_en = 1'b1;
`endif

    // ------------------------------------------------------------------
    // Next-state / output-register logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rr_d    = rr_next;
        we_d    = 1'b0;
        // Address and data hold across idle cycles; only EscrReg drops.
        addr_d  = addr_q;
        data_d  = data_q;

        unique case (state_q)
            ST_CLEAR: begin
                we_d   = 1'b1;
                addr_d = cnt_q;
                data_d = '0;
                if (cnt_q == CLR_LAST) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + ADDR_W'(1);
                end
            end

            ST_RUN: begin
                if (clear_req) begin
                    // Whatever write is already in the output registers still
                    // reaches the bank at the coming edge; nothing new is issued.
                    state_d = ST_CLEAR;
                    cnt_d   = '0;
                end else if (grant_a) begin
                    we_d   = a_wr_en;
                    addr_d = a_addr;
                    data_d = a_data;
                end else if (grant_b) begin
                    we_d   = b_wr_en;
                    addr_d = b_addr;
                    data_d = b_data;
                end
            end

            default: begin
                state_d = ST_CLEAR;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_CLEAR;
            cnt_q   <= '0;
            rr_q    <= RR_A;
            we_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rr_q    <= rr_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    assign EscrReg = we_q;
    assign RegEscr = addr_q;
    assign datain  = data_q;

endmodule : regbank_write_arbiter

// File: tb/tb_regbank_write_arbiter.sv
module tb_regbank_write_arbiter;

  localparam int DW = 32;
  localparam int AW = 6;
  localparam int NR = 64;

`ifdef REGBANK_ARB_R0_ZERO_EN
  localparam bit R0_ZERO = 1'b1;
`else
  localparam bit R0_ZERO = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic          clear_req;
  logic          a_valid, b_valid;
  logic [AW-1:0] a_addr, b_addr;
  logic [DW-1:0] a_data, b_data;
  logic          a_ready, b_ready, busy, EscrReg;
  logic [AW-1:0] RegEscr;
  logic [DW-1:0] datain;

  regbank_write_arbiter dut (
    .clk       (clk),
    .reset     (reset),
    .clear_req (clear_req),
    .a_valid   (a_valid),
    .a_addr    (a_addr),
    .a_data    (a_data),
    .a_ready   (a_ready),
    .b_valid   (b_valid),
    .b_addr    (b_addr),
    .b_data    (b_data),
    .b_ready   (b_ready),
    .busy      (busy),
    .RegEscr   (RegEscr),
    .EscrReg   (EscrReg),
    .datain    (datain)
  );

  // ---------------- bank model (the arbiter's load) ----------------
  logic [DW-1:0] bank [NR];
  initial for (int i = 0; i < NR; i++) bank[i] = 32'hDEAD_0000 | DW'(i);
  always @(posedge clk) if (EscrReg) bank[RegEscr] <= datain;

  // ---------------- scoreboard ----------------
  int pass_cnt = 0;
  int total_cnt = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic          av;
    logic [AW-1:0] aa;
    logic [DW-1:0] ad;
    logic          bv;
    logic [AW-1:0] ba;
    logic [DW-1:0] bd;
    logic          ar;   // expected a_ready
    logic          br;   // expected b_ready
    logic          we;   // expected EscrReg next cycle
    logic          ck;   // compare RegEscr/datain next cycle
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
  } vec_t;

  localparam int NV = 15;
  vec_t vecs [NV];

  // ---------------- driver tasks ----------------
  task automatic drive_idle();
    clear_req = 1'b0;
    a_valid = 1'b0; a_addr = '0; a_data = '0;
    b_valid = 1'b0; b_addr = '0; b_data = '0;
  endtask

  // Caller sits at posedge+#1 with the DUT in CLEAR and cnt=0.
  task automatic check_clear_seq(input string tag);
    for (int i = 0; i < NR; i++) begin
      @(posedge clk); #1;
      chk({tag, "_we"},   DW'(EscrReg), 32'd1);
      chk({tag, "_addr"}, DW'(RegEscr), DW'(i));
      chk({tag, "_data"}, datain, 32'd0);
      chk({tag, "_busy"}, DW'(busy), DW'(i < NR - 1));
      if (i == 30) chk({tag, "_a_ready"}, DW'(a_ready), 32'd0);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    // Table: rr_pri starts at A after the reset clear.
    //           av aa  ad           bv ba  bd        ar br we ck wa  wd
    vecs[0]  = '{1, 5,  32'h1,       0, 0,  32'h0,    1, 0, 1, 1, 5,  32'h1};
    vecs[1]  = '{1, 2,  32'hA,       1, 3,  32'hB,    1, 0, 1, 1, 2,  32'hA};
    vecs[2]  = '{1, 2,  32'hA,       1, 3,  32'hB,    0, 1, 1, 1, 3,  32'hB};
    vecs[3]  = '{1, 2,  32'hA,       1, 3,  32'hB,    1, 0, 1, 1, 2,  32'hA};
    vecs[4]  = '{1, 2,  32'hA,       1, 3,  32'hB,    0, 1, 1, 1, 3,  32'hB};
    vecs[5]  = '{0, 0,  32'h0,       0, 0,  32'h0,    0, 0, 0, 1, 3,  32'hB};
    vecs[6]  = '{0, 0,  32'h0,       1, 7,  32'h77,   0, 1, 1, 1, 7,  32'h77};
    vecs[7]  = '{1, 8,  32'h88,      1, 9,  32'h99,   1, 0, 1, 1, 8,  32'h88};
    vecs[8]  = '{1, 10, 32'h1010,    0, 0,  32'h0,    1, 0, 1, 1, 10, 32'h1010};
    vecs[9]  = '{1, 11, 32'h11,      1, 12, 32'h12,   0, 1, 1, 1, 12, 32'h12};
    vecs[10] = '{0, 0,  32'h0,       1, 13, 32'h13,   0, 1, 1, 1, 13, 32'h13};
    vecs[11] = '{1, 14, 32'h14,      1, 15, 32'h15,   1, 0, 1, 1, 14, 32'h14};
    vecs[12] = '{1, 0,  32'hFFFFFFFF,0, 0,  32'h0,    1, 0, !R0_ZERO, !R0_ZERO, 0, 32'hFFFFFFFF};
    vecs[13] = '{1, 30, 32'h1,       0, 0,  32'h0,    1, 0, 1, 1, 30, 32'h1};
    vecs[14] = '{0, 0,  32'h0,       1, 30, 32'h2,    0, 1, 1, 1, 30, 32'h2};

    drive_idle();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    // Reset state
    chk("rst_we",      DW'(EscrReg), 32'd0);
    chk("rst_addr",    DW'(RegEscr), 32'd0);
    chk("rst_data",    datain, 32'd0);
    chk("rst_busy",    DW'(busy), 32'd1);
    chk("rst_a_ready", DW'(a_ready), 32'd0);
    reset = 1'b0;

    check_clear_seq("clr0");
    chk("clr0_reg0", bank[0], 32'd0);
    chk("clr0_reg1", bank[1], 32'd0);

    // Table-driven RUN traffic
    for (int v = 0; v < NV; v++) begin
      a_valid = vecs[v].av; a_addr = vecs[v].aa; a_data = vecs[v].ad;
      b_valid = vecs[v].bv; b_addr = vecs[v].ba; b_data = vecs[v].bd;
      #1;
      chk($sformatf("v%0d_a_ready", v), DW'(a_ready), DW'(vecs[v].ar));
      chk($sformatf("v%0d_b_ready", v), DW'(b_ready), DW'(vecs[v].br));
      @(posedge clk); #1;
      chk($sformatf("v%0d_we", v), DW'(EscrReg), DW'(vecs[v].we));
      if (vecs[v].ck) begin
        chk($sformatf("v%0d_addr", v), DW'(RegEscr), DW'(vecs[v].wa));
        chk($sformatf("v%0d_data", v), datain, vecs[v].wd);
      end
      if (v == 0) chk("lat_reg5_not_yet", bank[5], 32'd0);
      if (v == 1) chk("lat_reg5_updated", bank[5], 32'd1);
    end
    drive_idle();
    @(posedge clk); #1;
    chk("idle_we", DW'(EscrReg), 32'd0);
    chk("reg5",  bank[5],  32'h1);
    chk("reg2",  bank[2],  32'hA);
    chk("reg3",  bank[3],  32'hB);
    chk("reg7",  bank[7],  32'h77);
    chk("reg8",  bank[8],  32'h88);
    chk("reg9",  bank[9],  32'h0);
    chk("reg10", bank[10], 32'h1010);
    chk("reg11", bank[11], 32'h0);
    chk("reg12", bank[12], 32'h12);
    chk("reg13", bank[13], 32'h13);
    chk("reg14", bank[14], 32'h14);
    chk("reg15", bank[15], 32'h0);
    chk("reg30_last_wins", bank[30], 32'h2);
    chk("reg0", bank[0], R0_ZERO ? 32'h0 : 32'hFFFFFFFF);

    // clear_req beats simultaneous valids
    clear_req = 1'b1;
    a_valid = 1'b1; a_addr = 6'd20; a_data = 32'h20;
    b_valid = 1'b1; b_addr = 6'd21; b_data = 32'h21;
    #1;
    chk("clrq_a_ready", DW'(a_ready), 32'd0);
    chk("clrq_b_ready", DW'(b_ready), 32'd0);
    @(posedge clk); #1;
    clear_req = 1'b0;
    b_valid = 1'b0;
    chk("clrq_busy", DW'(busy), 32'd1);
    chk("clrq_we",   DW'(EscrReg), 32'd0);
    check_clear_seq("clr1");
    // First RUN cycle: held A request is taken now.
    chk("clr1_a_first", DW'(a_ready), 32'd1);
    @(posedge clk); #1;
    a_valid = 1'b0;
    chk("clr1_a_we",   DW'(EscrReg), 32'd1);
    chk("clr1_a_addr", DW'(RegEscr), 32'd20);
    chk("clr1_a_data", datain, 32'h20);
    @(posedge clk); #1;
    for (int r = 0; r < NR; r++)
      chk($sformatf("clr1_reg%0d", r), bank[r], (r == 20) ? 32'h20 : 32'h0);

    // Reset in the middle of a clear
    clear_req = 1'b1;
    @(posedge clk); #1;
    clear_req = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    chk("midclr_addr19", DW'(RegEscr), 32'd19);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("midclr_rst_addr", DW'(RegEscr), 32'd0);
    chk("midclr_rst_we",   DW'(EscrReg), 32'd0);
    chk("midclr_rst_busy", DW'(busy), 32'd1);
    reset = 1'b0;
    check_clear_seq("clr2");

    // Reset during RUN drops a pending request
    a_valid = 1'b1; a_addr = 6'd40; a_data = 32'h40;
    reset = 1'b1;
    #1;
    chk("runrst_a_ready", DW'(a_ready), 32'd0);
    @(posedge clk); #1;
    chk("runrst_we",   DW'(EscrReg), 32'd0);
    chk("runrst_busy", DW'(busy), 32'd1);
    reset = 1'b0;
    drive_idle();
    check_clear_seq("clr3");

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/regbank_write_arbiter.md
Name: regbank_write_arbiter

Overview:
- Owns the single write port of the 64x32 register bank.
- Arbitrates writes between two requesters: port A (ALU writeback) and port B (load/memory writeback), using valid/ready handshakes and round-robin priority.
- After reset, or on request, sequences a full clear of the bank, writing 0 to every register, one register per cycle.
- Drives the bank's RegEscr / EscrReg / datain directly from registered outputs.

Parameters:
- DATA_W, 32: data width of the bank.
- ADDR_W, 6: register address width.
- NUM_REGS, 64: number of registers cleared; must be ≤ 2**ADDR_W.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- clear_req  in  1  one-cycle pulse; starts a bank clear.
- a_valid  in  1  requester A has a write pending.
- a_addr  in  ADDR_W  requester A target register.
- a_data  in  DATA_W  requester A write data.
- a_ready  out  1  A accepted this cycle when a_valid & a_ready.
- b_valid  in  1  requester B has a write pending.
- b_addr  in  ADDR_W  requester B target register.
- b_data  in  DATA_W  requester B write data.
- b_ready  out  1  B accepted this cycle when b_valid & b_ready.
- busy  out  1  high while a clear sequence is running.
- RegEscr  out  ADDR_W  bank write address (registered).
- EscrReg  out  1  bank write enable (registered).
- datain  out  DATA_W  bank write data (registered).

Behaviour:
- Reset: clk is the single clock; reset is synchronous and active-high. On reset, state=CLEAR, clear counter cnt=0, rr_pri=A, and EscrReg=0, RegEscr=0, datain=0. busy=1 in the first cycle after reset.
- States: CLEAR and RUN.
- busy=1 exactly when state=CLEAR.
- a_ready and b_ready are combinational and are 0 in CLEAR.
- CLEAR:
  - Each cycle registers EscrReg=1, RegEscr=cnt, datain=0, then cnt++.
  - When the write for cnt=NUM_REGS-1 is registered, the next state is RUN and cnt=0.
  - clear_req is ignored during CLEAR.
  - Clear duration: exactly NUM_REGS cycles.
- RUN arbitration, evaluated each cycle when clear_req=0:
  - Only a_valid: a_ready=1.
  - Only b_valid: b_ready=1.
  - Both valid: ready goes to the side named by rr_pri; rr_pri then flips to the other side.
  - Single-requester grants leave rr_pri unchanged.
  - At most one ready is high per cycle.
- Write issue:
  - The accepted request is registered at the same edge: EscrReg=1, RegEscr=addr, datain=data.
  - The bank samples it on the following edge.
  - Latency: handshake in cycle N → EscrReg high in cycle N+1 → bank content updated at end of N+1.
- Idle: with no grant and not in CLEAR, EscrReg=0 in the next cycle. RegEscr and datain hold their last values.
- clear_req in RUN:
  - The next state is CLEAR.
  - Both readies are 0 in that cycle; clear wins over simultaneous valids.
  - A write already registered (issued in the previous cycle) still completes.
- Throughput: one write per cycle, sustained.
- Requesters hold valid, addr and data stable until accepted.
- Back-to-back writes to the same address: the later grant wins, in grant order.
- Reset asserted mid-CLEAR or mid-RUN: returns to CLEAR with cnt=0. Any pending requests are dropped (not accepted).

Optional Feature:
- Macro: REGBANK_ARB_R0_ZERO_EN.
- When defined:
  - Accepted writes with addr==0 still complete the handshake (ready=1), but EscrReg stays 0, so register 0 stays hard-wired to zero.
  - CLEAR still writes 0 to register 0.
- When undefined: register 0 is writable like any other register.

Decomposition:
- Shared package regbank_pkg holds:
  - constants DATA_W=32, ADDR_W=6, NUM_REGS=64;
  - state encoding ST_CLEAR=1'b0, ST_RUN=1'b1;
  - requester id constants RR_A=1'b0, RR_B=1'b1.
- One natural sub-module: rr_arbiter2. It takes the two valids, rr_pri and an enable, and outputs grant_a, grant_b and next rr_pri (all combinational).
- The top module keeps the FSM, clear counter and output registers.

Test Plan:
- Reset release → busy=1 for 64 cycles; EscrReg=1 with RegEscr stepping 0..63 and datain=0; then busy=0. Reading regs 0 and 1 afterwards returns 0.
- RUN, a_valid with a_addr=5, a_data=0x00000001 → a_ready=1 in cycle N; EscrReg=1, RegEscr=5, datain=1 in N+1; reg 5 reads 1 in N+2.
- Both valid for 4 cycles (A: addr 2, data 0xA; B: addr 3, data 0xB; each re-presented after acceptance) → grants A,B,A,B. Only one ready per cycle. Reg2=0xA and reg3=0xB.
- clear_req pulsed together with a_valid in RUN → a_ready=0; busy rises next cycle; all 64 registers read 0 after 64 cycles. A then accepted in the first RUN cycle.
- reset asserted at clear cycle 20 → next cycle RegEscr=0 with cnt restarted; full 64-cycle clear follows.
- With REGBANK_ARB_R0_ZERO_EN defined: A writes addr 0, data 0xFFFFFFFF → a_ready=1, EscrReg stays 0, reg0 reads 0. Without the macro, reg0 reads 0xFFFFFFFF.
